// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard device block.
//   ps2_state_e : receiver FSM states
//   BIT_*       : bit positions inside the 32-bit status/data word
//   sat_count   : clamps a FIFO occupancy value to the 4-bit count field
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam int unsigned BIT_NONEMPTY = 31;
  localparam int unsigned BIT_OVF      = 30;
  localparam int unsigned BIT_PAR      = 29;
  localparam int unsigned BIT_FRM      = 28;
  localparam int unsigned CNT_HI       = 27;
  localparam int unsigned CNT_LO       = 24;

  function automatic logic [3:0] sat_count(input logic [4:0] c);
    return (c > 5'd15) ? 4'hF : c[3:0];
  endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// Synchronous show-ahead FIFO of 8-bit scan codes.
//   clk, rst : device clock, synchronous active-high reset
//   push/din : write request and byte; accepted when not full, or when full
//              and a pop happens in the same cycle
//   pop      : read request; ignored while empty
//   head     : byte at the read pointer (valid only when !empty)
//   full, empty, count : occupancy status
module ps2_byte_fifo #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [7:0]                    din,
  input  logic                          pop,
  output logic [7:0]                    head,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(FIFO_DEPTH));
  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

  // When full, a simultaneous pop frees the slot the push writes into
  // (wr_ptr == rd_ptr), so both may proceed in one cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (AW+1)'(1);
      2'b01:   cnt_d = cnt_q - (AW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ps2_keyboard_dev_io.sv
// Bus-mapped PS/2 keyboard receiver.
//   clk, rst : device clock, synchronous active-high reset
//   ps2_clk, ps2_data : raw asynchronous PS/2 lines
//   rd_en    : one-cycle pulse pops the FIFO head
//   clr_err  : clears the sticky ovf/par_err/frm_err bits
//   data_out : {nonempty, ovf, par_err, frm_err, count[3:0], 16'h0, head}
//   irq      : high while the scan-code FIFO is non-empty
module ps2_keyboard_dev_io #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 25000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        rd_en,
  input  logic        clr_err,
  output logic [31:0] data_out,
  output logic        irq
);

  import ps2_pkg::*;

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  // input conditioning
  logic          clk_meta_q, clk_meta_d, clk_sync_q, clk_sync_d;
  logic          data_meta_q, data_meta_d, data_sync_q, data_sync_d;
  logic          filt_clk_q, filt_clk_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall_q, fall_d;

  // receiver
  ps2_state_e    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_bit_q, par_bit_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          timeout;

  // sticky status
  logic          ovf_q, ovf_d, par_q, par_d, frm_q, frm_d;

  // output-comb events
  logic          stop_evt, parity_ok, push, par_evt, frm_evt, ovf_evt;

  // fifo
  logic [7:0]    fifo_head;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;

  ps2_byte_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (shreg_q),
    .pop   (rd_en),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Synchronizers, glitch filter and falling-edge detector.
  // filt_cnt counts consecutive synced samples that disagree with the
  // filtered clock; any agreeing sample restarts the count.
  always_comb begin
    clk_meta_d  = ps2_clk;
    clk_sync_d  = clk_meta_q;
    data_meta_d = ps2_data;
    data_sync_d = data_meta_q;
    filt_clk_d  = filt_clk_q;
    filt_cnt_d  = '0;
    if (clk_sync_q != filt_clk_q) begin
      if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
        filt_clk_d = clk_sync_q;
      end else begin
        filt_cnt_d = filt_cnt_q + FW'(1);
      end
    end
    fall_d = filt_clk_q && !filt_clk_d;
  end

  // A sample event wins over a coincident timeout: the edge arrived in time.
  assign timeout = (state_q != IDLE) && !fall_q &&
                   (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    par_bit_d = par_bit_q;
    tmo_cnt_d = (state_q == IDLE || fall_q) ? '0 : tmo_cnt_q + TW'(1);
    if (timeout) begin
      state_d = IDLE;
    end else if (fall_q) begin
      case (state_q)
        IDLE: begin
          if (!data_sync_q) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end
        end
        DATA: begin
          shreg_d = {data_sync_q, shreg_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        PARITY: begin
          par_bit_d = data_sync_q;
          state_d   = STOP;
        end
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output logic: frame-completion events and sticky error updates
  always_comb begin
    stop_evt  = fall_q && (state_q == STOP);
    parity_ok = ^{par_bit_q, shreg_q};
    push      = stop_evt && data_sync_q && parity_ok;
    par_evt   = stop_evt && !parity_ok;
    frm_evt   = (stop_evt && !data_sync_q) || timeout;
    // full implies non-empty, so rd_en alone decides whether the pop frees a slot
    ovf_evt   = push && fifo_full && !rd_en;
    ovf_d     = (ovf_q && !clr_err) || ovf_evt;
    par_d     = (par_q && !clr_err) || par_evt;
    frm_d     = (frm_q && !clr_err) || frm_evt;

    data_out                  = '0;
    data_out[BIT_NONEMPTY]    = !fifo_empty;
    data_out[BIT_OVF]         = ovf_q;
    data_out[BIT_PAR]         = par_q;
    data_out[BIT_FRM]         = frm_q;
    data_out[CNT_HI:CNT_LO]   = sat_count(5'(fifo_count));
    data_out[7:0]             = fifo_empty ? 8'h00 : fifo_head;
    irq                       = !fifo_empty;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      filt_clk_q  <= 1'b1;
      filt_cnt_q  <= '0;
      fall_q      <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      par_bit_q   <= 1'b0;
      tmo_cnt_q   <= '0;
      ovf_q       <= 1'b0;
      par_q       <= 1'b0;
      frm_q       <= 1'b0;
    end else begin
      clk_meta_q  <= clk_meta_d;
      clk_sync_q  <= clk_sync_d;
      data_meta_q <= data_meta_d;
      data_sync_q <= data_sync_d;
      filt_clk_q  <= filt_clk_d;
      filt_cnt_q  <= filt_cnt_d;
      fall_q      <= fall_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      par_bit_q   <= par_bit_d;
      tmo_cnt_q   <= tmo_cnt_d;
      ovf_q       <= ovf_d;
      par_q       <= par_d;
      frm_q       <= frm_d;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard_dev_io.sv
// Self-checking bench for ps2_keyboard_dev_io: drives PS/2 frames and compares
// the status/data word against a queue-based model of the device.
module tb_ps2_keyboard_dev_io;

  localparam int unsigned DEPTH = 8;
  localparam int          H     = 20;   // PS/2 half period in clk cycles

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic        rd_en = 1'b0;
  logic        clr_err = 1'b0;
  logic [31:0] data_out;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;

  // model
  logic [7:0] mq[$];
  logic       m_ovf = 1'b0, m_par = 1'b0, m_frm = 1'b0;

  always #5 clk = ~clk;

  ps2_keyboard_dev_io #(
    .FIFO_DEPTH     (DEPTH),
    .FILTER_LEN     (4),
    .TIMEOUT_CYCLES (25000)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rd_en    (rd_en),
    .clr_err  (clr_err),
    .data_out (data_out),
    .irq      (irq)
  );

  function automatic logic [31:0] exp_word();
    logic [31:0] w;
    int n;
    n = mq.size();
    w = 32'h0;
    w[31]    = (n != 0);
    w[30]    = m_ovf;
    w[29]    = m_par;
    w[28]    = m_frm;
    w[27:24] = (n > 15) ? 4'hF : 4'(n);
    w[7:0]   = (n != 0) ? mq[0] : 8'h00;
    return w;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Good frames are pushed (or dropped as overflow); bad ones set error bits.
  task automatic model_frame(input logic [7:0] b, input logic par_ok,
                             input logic stop_ok, input logic pop_same);
    if (pop_same && mq.size() > 0) void'(mq.pop_front());
    if (!par_ok)  m_par = 1'b1;
    if (!stop_ok) m_frm = 1'b1;
    if (par_ok && stop_ok) begin
      if (mq.size() < DEPTH) mq.push_back(b);
      else m_ovf = 1'b1;
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0; m_par = 1'b0; m_frm = 1'b0;
  endtask

  // Sends the first nbits bits of a frame, LSB first (start, 8 data, parity, stop).
  task automatic send_frame(input logic [7:0] b, input logic par_flip,
                            input logic stop_bit, input int nbits,
                            input logic glitch, input logic rd_at_stop);
    logic [10:0] fr;
    fr = {stop_bit, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = fr[i];
      if (glitch) begin
        cyc(3); ps2_clk = 1'b0; cyc(2); ps2_clk = 1'b1; cyc(H/2 - 5);
      end else begin
        cyc(H/2);
      end
      ps2_clk = 1'b0;
      for (int k = 1; k <= H; k++) begin
        @(negedge clk);
        // rd_en lands on the same clk edge as the stop-bit push
        if (rd_at_stop && i == 10 && k == 6) rd_en = 1'b1;
        if (rd_at_stop && i == 10 && k == 7) rd_en = 1'b0;
      end
      ps2_clk = 1'b1;
      cyc(H/2);
    end
    ps2_data = 1'b1;
    cyc(H);
  endtask

  task automatic do_read();
    rd_en = 1'b1; cyc(1); rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic do_clr();
    clr_err = 1'b1; cyc(1); clr_err = 1'b0;
    m_ovf = 1'b0; m_par = 1'b0; m_frm = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; cyc(3);
    n_checks++;
    if (data_out !== 32'h0) begin n_fail++; $display("FAIL reset_word: got %h want %h", data_out, 32'h0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst = 1'b0; cyc(2);
    model_reset();
  endtask

  task automatic test_single();
    send_frame(8'h1C, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    model_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 32'h8100001C) begin n_fail++; $display("FAIL single_word: got %h want %h", data_out, 32'h8100001C); end
    n_checks++;
    if (irq !== 1'b1) begin n_fail++; $display("FAIL single_irq: got %b want 1", irq); end
    do_read(); cyc(1);
    n_checks++;
    if (data_out !== 32'h0) begin n_fail++; $display("FAIL single_pop_word: got %h want %h", data_out, 32'h0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL single_pop_irq: got %b want 0", irq); end
    // rd_en on an empty FIFO must change nothing
    do_read(); cyc(1);
    n_checks++;
    if (data_out !== 32'h0) begin n_fail++; $display("FAIL empty_read: got %h want %h", data_out, 32'h0); end
  endtask

  task automatic test_parity_err();
    send_frame(8'hF0, 1'b1, 1'b1, 11, 1'b0, 1'b0);
    model_frame(8'hF0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 32'h20000000) begin n_fail++; $display("FAIL parity_word: got %h want %h", data_out, 32'h20000000); end
    do_clr(); cyc(1);
    n_checks++;
    if (data_out !== 32'h0) begin n_fail++; $display("FAIL parity_clr: got %h want %h", data_out, 32'h0); end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) begin
      send_frame(8'(i), 1'b0, 1'b1, 11, 1'b0, 1'b0);
      model_frame(8'(i), 1'b1, 1'b1, 1'b0);
    end
    n_checks++;
    if (data_out !== 32'hC8000001) begin n_fail++; $display("FAIL ovf_word: got %h want %h", data_out, 32'hC8000001); end
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (data_out[7:0] !== 8'(i)) begin n_fail++; $display("FAIL ovf_read_%0d: got %h want %h", i, data_out[7:0], 8'(i)); end
      do_read();
    end
    n_checks++;
    if (data_out !== exp_word()) begin n_fail++; $display("FAIL ovf_drained: got %h want %h", data_out, exp_word()); end
    do_clr();
  endtask

  task automatic test_timeout();
    send_frame(8'h55, 1'b0, 1'b1, 4, 1'b0, 1'b0);
    cyc(25100);
    m_frm = 1'b1;
    n_checks++;
    if (data_out !== 32'h10000000) begin n_fail++; $display("FAIL timeout_word: got %h want %h", data_out, 32'h10000000); end
    send_frame(8'h2A, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    model_frame(8'h2A, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 32'h9100002A) begin n_fail++; $display("FAIL timeout_next: got %h want %h", data_out, 32'h9100002A); end
    do_read(); do_clr(); cyc(1);
  endtask

  task automatic test_glitch();
    send_frame(8'h5A, 1'b0, 1'b1, 11, 1'b1, 1'b0);
    model_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== 32'h8100005A) begin n_fail++; $display("FAIL glitch_word: got %h want %h", data_out, 32'h8100005A); end
    do_read();
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b0, 1'b1, 11, 1'b0, 1'b0);
      model_frame(b, 1'b1, 1'b1, 1'b0);
    end
    send_frame(8'h33, 1'b0, 1'b1, 11, 1'b0, 1'b1);
    model_frame(8'h33, 1'b1, 1'b1, 1'b1);
    n_checks++;
    if (data_out !== exp_word()) begin n_fail++; $display("FAIL b2b_word: got %h want %h", data_out, exp_word()); end
    n_checks++;
    if (data_out[30] !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf: got %b want 0", data_out[30]); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (data_out !== exp_word()) begin n_fail++; $display("FAIL b2b_read_%0d: got %h want %h", i, data_out, exp_word()); end
      if (i == 7) begin
        n_checks++;
        if (data_out[7:0] !== 8'h33) begin n_fail++; $display("FAIL b2b_last: got %h want 33", data_out[7:0]); end
      end
      do_read();
    end
  endtask

  task automatic test_reset_mid_frame();
    send_frame(8'h11, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    model_frame(8'h11, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== exp_word()) begin n_fail++; $display("FAIL midrst_pre: got %h want %h", data_out, exp_word()); end
    send_frame(8'h77, 1'b0, 1'b1, 5, 1'b0, 1'b0);
    rst = 1'b1; cyc(1);
    model_reset();
    n_checks++;
    if (data_out !== 32'h0) begin n_fail++; $display("FAIL midrst_word: got %h want %h", data_out, 32'h0); end
    n_checks++;
    if (irq !== 1'b0) begin n_fail++; $display("FAIL midrst_irq: got %b want 0", irq); end
    rst = 1'b0; cyc(4);
    send_frame(8'h6B, 1'b0, 1'b1, 11, 1'b0, 1'b0);
    model_frame(8'h6B, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if (data_out !== exp_word()) begin n_fail++; $display("FAIL midrst_after: got %h want %h", data_out, exp_word()); end
    do_read();
  endtask

  task automatic test_random();
    logic [7:0] b;
    int r;
    logic pf, sb;
    for (int i = 0; i < 14; i++) begin
      b  = 8'($urandom_range(0, 255));
      r  = $urandom_range(0, 5);
      pf = (r == 3 || r == 5);
      sb = !(r == 4 || r == 5);
      send_frame(b, pf, sb, 11, 1'b0, 1'b0);
      model_frame(b, !pf, sb, 1'b0);
      n_checks++;
      if (data_out !== exp_word()) begin n_fail++; $display("FAIL rand_frame_%0d: got %h want %h", i, data_out, exp_word()); end
      n_checks++;
      if (irq !== (mq.size() != 0)) begin n_fail++; $display("FAIL rand_irq_%0d: got %b want %b", i, irq, mq.size() != 0); end
      if ($urandom_range(0, 2) == 0) do_read();
      if ($urandom_range(0, 3) == 0) do_clr();
      cyc(1);
      n_checks++;
      if (data_out !== exp_word()) begin n_fail++; $display("FAIL rand_post_%0d: got %h want %h", i, data_out, exp_word()); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity_err();
    test_overflow();
    test_timeout();
    test_glitch();
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
